// File: rtl/csr_excp_unit_pkg.sv
// ============================================================================
// csr_excp_unit_pkg : CSR addresses, field positions and redirect FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package csr_excp_unit_pkg;

  localparam logic [13:0] CSR_CRMD      = 14'h0;
  localparam logic [13:0] CSR_PRMD      = 14'h1;
  localparam logic [13:0] CSR_ECFG      = 14'h4;
  localparam logic [13:0] CSR_ESTAT     = 14'h5;
  localparam logic [13:0] CSR_ERA       = 14'h6;
  localparam logic [13:0] CSR_BADV      = 14'h7;
  localparam logic [13:0] CSR_EENTRY    = 14'hC;
  localparam logic [13:0] CSR_TLBEHI    = 14'h11;
  localparam logic [13:0] CSR_TLBRENTRY = 14'h88;

  localparam int CRMD_PLV       = 0;
  localparam int CRMD_IE        = 2;
  localparam int CRMD_DA        = 3;
  localparam int CRMD_PG        = 4;
  localparam int PRMD_PPLV      = 0;
  localparam int PRMD_PIE       = 2;
  localparam int ESTAT_IS       = 0;
  localparam int ESTAT_ECODE    = 16;
  localparam int ESTAT_ESUBCODE = 22;

  localparam logic [5:0] ECODE_TLBR = 6'h3F;

  typedef enum logic [0:0] {
    RD_IDLE     = 1'b0,
    RD_REDIRECT = 1'b1
  } redir_state_t;

endpackage

`default_nettype wire

// File: rtl/csr_excp_unit_redirect.sv
// ============================================================================
// excp_redirect_ctrl : held redirect request with a two-state handshake FSM
// Rev 1.0
// ============================================================================
`default_nettype none

module excp_redirect_ctrl
  import csr_excp_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        evt_valid,
  input  logic [31:0] evt_pc,
  input  logic        redirect_ready,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  redir_state_t r_state;
  redir_state_t w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RD_IDLE;
      r_pc    <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // A fresh event always retargets, even when the old request is acked now.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      RD_IDLE: begin
        if (evt_valid) begin
          w_state_nxt = RD_REDIRECT;
          w_pc_nxt    = evt_pc;
        end
      end
      RD_REDIRECT: begin
        if (evt_valid) begin
          w_pc_nxt = evt_pc;
        end else if (redirect_ready) begin
          w_state_nxt = RD_IDLE;
        end
      end
      default: w_state_nxt = RD_IDLE;
    endcase
  end

  assign redirect_valid = (r_state == RD_REDIRECT);
  assign redirect_pc    = r_pc;

endmodule

`default_nettype wire

// File: rtl/csr_excp_unit.sv
// ============================================================================
// csr_excp_unit : exception/ERTN CSR side effects, interrupt view, redirect
// Optional TLB exception support via macro CSR_TLB_EXCP_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module csr_excp_unit
  import csr_excp_unit_pkg::*;
#(
  parameter logic [31:0] ERA_RST    = 32'h0,
  parameter logic [31:0] EENTRY_RST = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        excp_flush,
  input  logic        ertn_flush,
  input  logic [5:0]  csr_ecode,
  input  logic [8:0]  csr_esubcode,
  input  logic [31:0] csr_era,
  input  logic        va_error,
  input  logic [31:0] bad_va,
  input  logic        excp_tlb,
  input  logic [18:0] excp_tlb_vppn,
  input  logic        excp_tlbrefill,
  input  logic        wb_csr_we,
  input  logic [13:0] wb_csr_addr,
  input  logic [31:0] wb_csr_data,
  input  logic [13:0] csr_raddr,
  output logic [31:0] csr_rdata,
  input  logic [7:0]  hw_int,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        int_req,
  output logic [1:0]  crmd_plv,
  output logic        crmd_da,
  output logic        crmd_pg
);

  logic [1:0]  r_plv, w_plv;
  logic        r_ie, w_ie, r_da, w_da, r_pg, w_pg;
  logic [1:0]  r_pplv, w_pplv;
  logic        r_pie, w_pie;
  logic [12:0] r_lie, w_lie;
  logic [1:0]  r_is_sw, w_is_sw;
  logic [7:0]  r_is_hw;
  logic [5:0]  r_ecode, w_ecode;
  logic [8:0]  r_esub, w_esub;
  logic [31:0] r_era, w_era;
  logic [31:0] r_badv, w_badv;
  logic [25:0] r_eentry, w_eentry;
  logic [12:0] w_is;
  logic [31:0] w_target;
  logic        r_int_req;

`ifdef CSR_TLB_EXCP_EN
  logic [18:0] r_vppn, w_vppn;
  logic [31:0] r_tlbrentry, w_tlbrentry;
`else
  logic        w_unused_tlb;
  assign w_unused_tlb = ^{excp_tlb, excp_tlbrefill, excp_tlb_vppn};
`endif

  assign w_is = {3'b000, r_is_hw, r_is_sw};

  // The WB write lands first; the event then overlays only its own fields.
  always_comb begin
    w_plv = r_plv;   w_ie = r_ie;     w_da = r_da;       w_pg = r_pg;
    w_pplv = r_pplv; w_pie = r_pie;   w_lie = r_lie;     w_is_sw = r_is_sw;
    w_ecode = r_ecode; w_esub = r_esub; w_era = r_era;   w_badv = r_badv;
    w_eentry = r_eentry;
`ifdef CSR_TLB_EXCP_EN
    w_vppn = r_vppn; w_tlbrentry = r_tlbrentry;
`endif
    if (wb_csr_we) begin
      case (wb_csr_addr)
        CSR_CRMD: begin
          w_plv = wb_csr_data[CRMD_PLV +: 2];
          w_ie  = wb_csr_data[CRMD_IE];
          w_da  = wb_csr_data[CRMD_DA];
          w_pg  = wb_csr_data[CRMD_PG];
        end
        CSR_PRMD: begin
          w_pplv = wb_csr_data[PRMD_PPLV +: 2];
          w_pie  = wb_csr_data[PRMD_PIE];
        end
        CSR_ECFG:   w_lie    = wb_csr_data[12:0];
        CSR_ESTAT:  w_is_sw  = wb_csr_data[ESTAT_IS +: 2];
        CSR_ERA:    w_era    = wb_csr_data;
        CSR_BADV:   w_badv   = wb_csr_data;
        CSR_EENTRY: w_eentry = wb_csr_data[31:6];
`ifdef CSR_TLB_EXCP_EN
        CSR_TLBEHI:    w_vppn      = wb_csr_data[31:13];
        CSR_TLBRENTRY: w_tlbrentry = wb_csr_data;
`endif
        default: ;
      endcase
    end

    w_target = {w_eentry, 6'b0};
    if (excp_flush) begin
      w_pplv  = w_plv;
      w_pie   = w_ie;
      w_plv   = 2'b00;
      w_ie    = 1'b0;
      w_ecode = csr_ecode;
      w_esub  = csr_esubcode;
      w_era   = csr_era;
      if (va_error) w_badv = bad_va;
`ifdef CSR_TLB_EXCP_EN
      if (excp_tlb) w_vppn = excp_tlb_vppn;
      if (excp_tlbrefill) begin
        w_da     = 1'b1;
        w_pg     = 1'b0;
        w_target = w_tlbrentry;
      end
`endif
    end else if (ertn_flush) begin
      w_plv    = w_pplv;
      w_ie     = w_pie;
      w_target = w_era;
`ifdef CSR_TLB_EXCP_EN
      if (w_ecode == ECODE_TLBR) begin
        w_da = 1'b0;
        w_pg = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_plv <= 2'b00;   r_ie <= 1'b0;    r_da <= 1'b1;     r_pg <= 1'b0;
      r_pplv <= 2'b00;  r_pie <= 1'b0;   r_lie <= 13'h0;   r_is_sw <= 2'b00;
      r_is_hw <= 8'h0;  r_ecode <= 6'h0; r_esub <= 9'h0;
      r_era <= ERA_RST; r_badv <= 32'h0; r_eentry <= EENTRY_RST[31:6];
      r_int_req <= 1'b0;
`ifdef CSR_TLB_EXCP_EN
      r_vppn <= 19'h0;  r_tlbrentry <= 32'h0;
`endif
    end else begin
      r_plv <= w_plv;     r_ie <= w_ie;       r_da <= w_da;       r_pg <= w_pg;
      r_pplv <= w_pplv;   r_pie <= w_pie;     r_lie <= w_lie;     r_is_sw <= w_is_sw;
      r_is_hw <= hw_int;  r_ecode <= w_ecode; r_esub <= w_esub;
      r_era <= w_era;     r_badv <= w_badv;   r_eentry <= w_eentry;
      r_int_req <= r_ie & (|(w_is & r_lie));
`ifdef CSR_TLB_EXCP_EN
      r_vppn <= w_vppn;   r_tlbrentry <= w_tlbrentry;
`endif
    end
  end

  always_comb begin
    csr_rdata = 32'h0;
    case (csr_raddr)
      CSR_CRMD:   csr_rdata = {27'b0, r_pg, r_da, r_ie, r_plv};
      CSR_PRMD:   csr_rdata = {29'b0, r_pie, r_pplv};
      CSR_ECFG:   csr_rdata = {19'b0, r_lie};
      CSR_ESTAT:  csr_rdata = {1'b0, r_esub, r_ecode, 3'b000, w_is};
      CSR_ERA:    csr_rdata = r_era;
      CSR_BADV:   csr_rdata = r_badv;
      CSR_EENTRY: csr_rdata = {r_eentry, 6'b0};
`ifdef CSR_TLB_EXCP_EN
      CSR_TLBEHI:    csr_rdata = {r_vppn, 13'b0};
      CSR_TLBRENTRY: csr_rdata = r_tlbrentry;
`endif
      default: csr_rdata = 32'h0;
    endcase
  end

  excp_redirect_ctrl u_redirect (
    .clk            (clk),
    .rst            (rst),
    .evt_valid      (excp_flush | ertn_flush),
    .evt_pc         (w_target),
    .redirect_ready (redirect_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  assign int_req  = r_int_req;
  assign crmd_plv = r_plv;
  assign crmd_da  = r_da;
  assign crmd_pg  = r_pg;

endmodule

`default_nettype wire
